inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 163 ++++++++++++++++
 tb/tb_inst_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot loader: takes a length-prefixed little-endian byte stream, writes it into instruction memory,
// then releases the CPU and counts run-phase cycles, stalls and flushes.
module inst_loader #(
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        imem_we_o,
    output logic [9:0]  imem_addr_o,
    output logic [31:0] imem_data_o,
    output logic        start_o,
    output logic        error_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        StLen0,
        StLen1,
        StData,
        StWrite,
        StRun,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic        alive_q;
    logic [15:0] len_q, len_d;
    logic [8:0]  idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] asm_q, asm_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        start_q;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] stl_q, stl_d;
    logic [31:0] fls_q, fls_d;

    logic        accept;
    logic [15:0] n_word;
    logic [8:0]  idx_inc;

    // alive_q keeps the loader from accepting bytes while reset is (or has just been) asserted.
    assign byte_ready_o = alive_q &&
                          (state_q == StLen0 || state_q == StLen1 || state_q == StData);
    assign accept       = byte_valid_i && byte_ready_o;
    assign imem_we_o    = (state_q == StWrite);
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign start_o      = start_q;
    assign error_o      = (state_q == StErr);
    assign cycle_cnt_o  = cyc_q;
    assign stall_cnt_o  = stl_q;
    assign flush_cnt_o  = fls_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        addr_d  = addr_q;
        data_d  = data_q;
        n_word  = {byte_i, len_q[7:0]};
        idx_inc = idx_q + 9'd1;

        unique case (state_q)
            StLen0: begin
                if (accept) begin
                    len_d[7:0] = byte_i;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    len_d = n_word;
                    if (n_word == 16'd0 || {1'b0, n_word} > MaxWords) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                        idx_d   = 9'd0;
                        bcnt_d  = 2'd0;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    if (bcnt_q == 2'd3) begin
                        data_d  = {byte_i, asm_q};
                        addr_d  = {idx_q[7:0], 2'b00};
                        bcnt_d  = 2'd0;
                        state_d = StWrite;
                    end else begin
                        case (bcnt_q)
                            2'd0:    asm_d[7:0]   = byte_i;
                            2'd1:    asm_d[15:8]  = byte_i;
                            default: asm_d[23:16] = byte_i;
                        endcase
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            StWrite: begin
                idx_d   = idx_inc;
                state_d = ({7'd0, idx_inc} < len_q) ? StData : StRun;
            end
            StRun:   state_d = StRun;
            StErr:   state_d = StErr;
            default: state_d = StLen0;
        endcase
    end

    // Saturating run-phase counters; frozen at zero until the CPU is released.
    always_comb begin
        cyc_d = cyc_q;
        stl_d = stl_q;
        fls_d = fls_q;
        if (state_q == StRun) begin
            if (cyc_q != 32'hFFFF_FFFF)            cyc_d = cyc_q + 32'd1;
            if (stall_i && stl_q != 32'hFFFF_FFFF) stl_d = stl_q + 32'd1;
            if (flush_i && fls_q != 32'hFFFF_FFFF) fls_d = fls_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StLen0;
            alive_q <= 1'b0;
            len_q   <= 16'd0;
            idx_q   <= 9'd0;
            bcnt_q  <= 2'd0;
            asm_q   <= 24'd0;
            addr_q  <= 10'd0;
            data_q  <= 32'd0;
            start_q <= 1'b0;
            cyc_q   <= 32'd0;
            stl_q   <= 32'd0;
            fls_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            start_q <= (state_d == StRun);
            cyc_q   <= cyc_d;
            stl_q   <= stl_d;
            fls_q   <= fls_d;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: header table, word loads, handshake gaps, counters, mid-load reset.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_d;
    logic        valid;
    logic        ready;
    logic        stall;
    logic        flush;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        start;
    logic        error;
    logic [31:0] cyc_cnt;
    logic [31:0] stl_cnt;
    logic [31:0] fls_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    inst_loader #(.MAX_WORDS(256)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .byte_i       (byte_d),
        .byte_valid_i (valid),
        .byte_ready_o (ready),
        .stall_i      (stall),
        .flush_i      (flush),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .start_o      (start),
        .error_o      (error),
        .cycle_cnt_o  (cyc_cnt),
        .stall_cnt_o  (stl_cnt),
        .flush_cnt_o  (fls_cnt)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       exp_err;
    } hdr_vec_t;

    wr_t        wq[$];
    logic [7:0] stream[$];
    logic       prev_we    = 1'b0;
    logic       prev_start = 1'b0;
    bit         start_seen = 1'b0;
    logic       start_after_we = 1'b0;

    // Write/start monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && imem_we) wq.push_back('{addr: imem_addr, data: imem_data});
        if (rst_n && start && !prev_start && !start_seen) begin
            start_seen     = 1'b1;
            start_after_we = prev_we;
        end
        prev_we    = imem_we;
        prev_start = start;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        valid  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        start_seen = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int  n  = 0;
        bit  ok = 1'b0;
        byte_d = b;
        valid  = 1'b1;
        while (n < 50) begin
            if (ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL byte accept timeout: byte 0x%02h not taken, expected acceptance", b);
        end
        if (gap) begin
            valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic load(input bit gap);
        foreach (stream[i]) send_byte(stream[i], gap);
        valid = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("start_o rises after load", 32'(start), 32'd1);
    endtask

    task automatic check_two_words(input string tag);
        check({tag, " write count"}, 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check({tag, " addr0"}, 32'(wq[0].addr), 32'h0);
            check({tag, " data0"}, wq[0].data, 32'h4433_2211);
            check({tag, " addr1"}, 32'(wq[1].addr), 32'h4);
            check({tag, " data1"}, wq[1].data, 32'h8877_6655);
        end
        check({tag, " start one cycle after last write"}, 32'(start_after_we), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"}, 32'(ready), 32'd0);
        check({tag, " we"}, 32'(imem_we), 32'd0);
        check({tag, " addr"}, 32'(imem_addr), 32'd0);
        check({tag, " data"}, imem_data, 32'd0);
        check({tag, " start"}, 32'(start), 32'd0);
        check({tag, " error"}, 32'(error), 32'd0);
        check({tag, " cycle_cnt"}, cyc_cnt, 32'd0);
        check({tag, " stall_cnt"}, stl_cnt, 32'd0);
        check({tag, " flush_cnt"}, fls_cnt, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        hdr_vec_t vecs[5];
        logic [7:0] b256[$];
        vecs[0] = '{lo: 8'h00, hi: 8'h00, exp_err: 1'b1};
        vecs[1] = '{lo: 8'h01, hi: 8'h01, exp_err: 1'b1};
        vecs[2] = '{lo: 8'h00, hi: 8'h01, exp_err: 1'b0};
        vecs[3] = '{lo: 8'h01, hi: 8'h00, exp_err: 1'b0};
        vecs[4] = '{lo: 8'hFF, hi: 8'hFF, exp_err: 1'b1};

        // Reset state and first-edge readiness.
        rst_n  = 1'b0;
        valid  = 1'b0;
        byte_d = 8'h00;
        stall  = 1'b0;
        flush  = 1'b0;
        #3;
        check_all_zero("in reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready before first edge", 32'(ready), 32'd0);
        @(negedge clk);
        check("ready after first edge", 32'(ready), 32'd1);

        // Header table.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            send_byte(vecs[v].lo, 1'b0);
            send_byte(vecs[v].hi, 1'b0);
            byte_d = 8'hAA;
            repeat (3) @(negedge clk);
            valid = 1'b0;
            check($sformatf("hdr%0d error", v), 32'(error), 32'(vecs[v].exp_err));
            check($sformatf("hdr%0d ready", v), 32'(ready), 32'(!vecs[v].exp_err));
            check($sformatf("hdr%0d start", v), 32'(start), 32'd0);
            check($sformatf("hdr%0d no write", v), 32'(wq.size()), 32'd0);
        end

        // Two-word load with stall/flush asserted throughout, which must be ignored.
        do_reset();
        stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        stall = 1'b1;
        flush = 1'b1;
        load(1'b0);
        wait_start(20);
        check("cycle_cnt zero at run entry", cyc_cnt, 32'd0);
        check("stall_cnt ignored outside run", stl_cnt, 32'd0);
        check("flush_cnt ignored outside run", fls_cnt, 32'd0);
        stall = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check_two_words("back-to-back");
        check("addr held after load", 32'(imem_addr), 32'h4);
        check("data held after load", imem_data, 32'h8877_6655);
        check("ready low in run", 32'(ready), 32'd0);

        // Same stream with valid toggling, then run-phase counters.
        do_reset();
        load(1'b1);
        wait_start(20);
        for (int i = 0; i < 10; i++) begin
            stall = (i >= 2 && i <= 4);
            flush = (i >= 4 && i <= 5);
            @(negedge clk);
        end
        stall = 1'b0;
        flush = 1'b0;
        check("cycle_cnt after 10", cyc_cnt, 32'd10);
        check("stall_cnt after 10", stl_cnt, 32'd3);
        check("flush_cnt after 10", fls_cnt, 32'd2);
        check_two_words("toggled valid");

        // Maximum-length load: 256 words.
        do_reset();
        stream = '{8'h00, 8'h01};
        for (int k = 0; k < 1024; k++) b256.push_back(8'(k * 7 + 3));
        foreach (b256[k]) stream.push_back(b256[k]);
        load(1'b0);
        wait_start(50);
        repeat (2) @(negedge clk);
        check("N=256 write count", 32'(wq.size()), 32'd256);
        if (wq.size() == 256) begin
            for (int w = 0; w < 256; w++) begin
                check($sformatf("N=256 addr%0d", w), 32'(wq[w].addr), 32'(w * 4));
                check($sformatf("N=256 data%0d", w), wq[w].data,
                      {b256[4*w+3], b256[4*w+2], b256[4*w+1], b256[4*w]});
            end
            check("N=256 last addr", 32'(wq[255].addr), 32'h3FC);
        end
        check("N=256 start after last write", 32'(start_after_we), 32'd1);

        // Reset after the 6th byte of a two-word load, then a fresh load.
        do_reset();
        stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        load(1'b0);
        @(negedge clk);
        check("partial load wrote word 0", imem_data, 32'h4433_2211);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset mid-load");
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        start_seen = 1'b0;
        @(negedge clk);
        check("ready after mid-load reset", 32'(ready), 32'd1);
        stream = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load(1'b0);
        wait_start(20);
        repeat (2) @(negedge clk);
        check_two_words("reload after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
